xgmii_port_switch: RTL and testbench

Parametrised N-port XGMII switch between the user application and the 10GBASE-R network paths, all on the 156.25 MHz XGMII clock. It fans the application TX stream out to a runtime-selectable set of ports and muxes one selectable port's RX stream back to the application. Enable and select changes are applied only at frame boundaries, so no port ever emits or delivers a truncated frame. When a selected link drops mid-frame, the block aborts the frame cleanly and resynchronises.

---
 rtl/xgmii_port_switch.sv | 194 +++++++++++++++++++
 tb/tb_xgmii_port_switch.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_port_switch.sv
// N-port XGMII switch: fans the application TX stream out to an enable mask of ports and muxes
// one port's RX stream back, changing mask/select only at frame boundaries.
module xgmii_port_switch #(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned SELW   = 2
) (
  input  logic                 xgmii_clk,
  input  logic                 sys_rst,
  input  logic [63:0]          app_txd,
  input  logic [7:0]           app_txc,
  input  logic [NPORTS-1:0]    tx_en_req,
  output logic [NPORTS*64-1:0] port_txd,
  output logic [NPORTS*8-1:0]  port_txc,
  input  logic [NPORTS*64-1:0] port_rxd,
  input  logic [NPORTS*8-1:0]  port_rxc,
  input  logic [NPORTS-1:0]    link_up,
  input  logic [SELW-1:0]      rx_sel_req,
  output logic [63:0]          app_rxd,
  output logic [7:0]           app_rxc,
  output logic [NPORTS-1:0]    tx_en_cur,
  output logic [SELW-1:0]      rx_sel_cur,
  output logic [31:0]          rx_frame_cnt,
  output logic [15:0]          rx_abort_cnt
);

  localparam logic [63:0] IdleD  = 64'h0707070707070707;
  localparam logic [7:0]  IdleC  = 8'hFF;
  localparam logic [63:0] AbortD = 64'h070707070707FDFE;

  typedef enum logic [0:0] {StSync, StPass} rx_st_e;

  // Bit 0: Start in lane 0, bit 1: Start in lane 4.
  function automatic logic [1:0] start_of(input logic [63:0] d, input logic [7:0] c);
    return {c[4] && (d[39:32] == 8'hFB), c[0] && (d[7:0] == 8'hFB)};
  endfunction

  function automatic logic has_term(input logic [63:0] d, input logic [7:0] c);
    logic r;
    r = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (c[k] && (d[8*k +: 8] == 8'hFD)) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [2:0] term_lane(input logic [63:0] d, input logic [7:0] c);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (c[k] && (d[8*k +: 8] == 8'hFD)) r = 3'(k);
    end
    return r;
  endfunction

  function automatic logic next_in_frame(input logic cur, input logic [63:0] d,
                                         input logic [7:0] c);
    logic [1:0] s;
    logic       t;
    logic [2:0] slane;
    s     = start_of(d, c);
    t     = has_term(d, c);
    slane = s[0] ? 3'd0 : 3'd4;
    if ((s != 2'b00) && (!t || (term_lane(d, c) < slane))) return 1'b1;
    if (t) return 1'b0;
    return cur;
  endfunction

  // ---------------- TX fan-out ----------------
  logic                 tx_in_frame_q;
  logic [NPORTS-1:0]    tx_en_q;
  logic [NPORTS*64-1:0] port_txd_q;
  logic [NPORTS*8-1:0]  port_txc_q;
  logic                 tx_boundary;

  assign tx_boundary = !tx_in_frame_q && (start_of(app_txd, app_txc) == 2'b00);

  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      tx_in_frame_q <= 1'b0;
      tx_en_q       <= '0;
      port_txd_q    <= {NPORTS{IdleD}};
      port_txc_q    <= {NPORTS{IdleC}};
    end else begin
      tx_in_frame_q <= next_in_frame(tx_in_frame_q, app_txd, app_txc);
      if (tx_boundary) tx_en_q <= tx_en_req;
      for (int unsigned i = 0; i < NPORTS; i++) begin
        port_txd_q[64*i +: 64] <= tx_en_q[i] ? app_txd : IdleD;
        port_txc_q[8*i +: 8]   <= tx_en_q[i] ? app_txc : IdleC;
      end
    end
  end

  // ---------------- RX mux ----------------
  rx_st_e          rx_state_q;
  logic [SELW-1:0] rx_sel_q;
  logic            rx_in_frame_q;
  logic [63:0]     app_rxd_q;
  logic [7:0]      app_rxc_q;
  logic [31:0]     rx_frame_cnt_q;
  logic [15:0]     rx_abort_cnt_q;

  logic [63:0] rx_d;
  logic [7:0]  rx_c;
  logic        rx_link;
  logic [1:0]  rx_start;
  logic        rx_term;
  logic [63:0] rx_mask_d;
  logic [7:0]  rx_mask_c;
  logic        rx_mask_term;
  logic        rx_sel_chg;

  always_comb begin
    rx_d    = '0;
    rx_c    = '0;
    rx_link = 1'b0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (rx_sel_q == SELW'(i)) begin
        rx_d    = port_rxd[64*i +: 64];
        rx_c    = port_rxc[8*i +: 8];
        rx_link = link_up[i];
      end
    end
  end

  // Lane-4 Start entered from SYNC: the preceding half-word belongs to no delivered frame.
  assign rx_mask_d    = {rx_d[63:32], IdleD[31:0]};
  assign rx_mask_c    = {rx_c[7:4], 4'hF};
  assign rx_start     = start_of(rx_d, rx_c);
  assign rx_term      = has_term(rx_d, rx_c);
  assign rx_mask_term = has_term(rx_mask_d, rx_mask_c);
  assign rx_sel_chg   = (32'(rx_sel_req) < NPORTS) && (rx_sel_req != rx_sel_q);

  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      rx_state_q     <= StSync;
      rx_sel_q       <= '0;
      rx_in_frame_q  <= 1'b0;
      app_rxd_q      <= IdleD;
      app_rxc_q      <= IdleC;
      rx_frame_cnt_q <= '0;
      rx_abort_cnt_q <= '0;
    end else begin
      rx_in_frame_q  <= next_in_frame(rx_in_frame_q, rx_d, rx_c);
      app_rxd_q      <= IdleD;
      app_rxc_q      <= IdleC;
      rx_frame_cnt_q <= rx_frame_cnt_q;
      rx_abort_cnt_q <= rx_abort_cnt_q;
      unique case (rx_state_q)
        StSync: begin
          if (rx_sel_chg) begin
            rx_sel_q <= rx_sel_req;
          end else if (rx_link && rx_start[0]) begin
            app_rxd_q  <= rx_d;
            app_rxc_q  <= rx_c;
            rx_state_q <= StPass;
            if (rx_term) rx_frame_cnt_q <= rx_frame_cnt_q + 32'd1;
          end else if (rx_link && rx_start[1]) begin
            app_rxd_q  <= rx_mask_d;
            app_rxc_q  <= rx_mask_c;
            rx_state_q <= StPass;
            if (rx_mask_term) rx_frame_cnt_q <= rx_frame_cnt_q + 32'd1;
          end
        end
        StPass: begin
          if (!rx_link) begin
            rx_state_q <= StSync;
            if (rx_in_frame_q) begin
              app_rxd_q <= AbortD;
              if (rx_abort_cnt_q != 16'hFFFF) rx_abort_cnt_q <= rx_abort_cnt_q + 16'd1;
            end
          end else if (rx_sel_chg && !rx_in_frame_q && (rx_start == 2'b00)) begin
            rx_sel_q   <= rx_sel_req;
            rx_state_q <= StSync;
          end else begin
            app_rxd_q <= rx_d;
            app_rxc_q <= rx_c;
            if (rx_term) rx_frame_cnt_q <= rx_frame_cnt_q + 32'd1;
          end
        end
        default: rx_state_q <= StSync;
      endcase
    end
  end

  assign port_txd     = port_txd_q;
  assign port_txc     = port_txc_q;
  assign tx_en_cur    = tx_en_q;
  assign app_rxd      = app_rxd_q;
  assign app_rxc      = app_rxc_q;
  assign rx_sel_cur   = rx_sel_q;
  assign rx_frame_cnt = rx_frame_cnt_q;
  assign rx_abort_cnt = rx_abort_cnt_q;

endmodule

// File: tb/tb_xgmii_port_switch.sv
// Random frame traffic on TX and all RX ports against a word-level reference model, followed by
// directed counter wrap/saturation checks.
module tb_xgmii_port_switch;

  localparam int NP = 4;
  localparam int SW = 2;
  localparam logic [63:0] IdleD  = 64'h0707070707070707;
  localparam logic [63:0] AbortD = 64'h070707070707FDFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             sys_rst;
  logic [63:0]      app_txd;
  logic [7:0]       app_txc;
  logic [NP-1:0]    tx_en_req;
  logic [NP*64-1:0] port_txd;
  logic [NP*8-1:0]  port_txc;
  logic [NP*64-1:0] port_rxd;
  logic [NP*8-1:0]  port_rxc;
  logic [NP-1:0]    link_up;
  logic [SW-1:0]    rx_sel_req;
  logic [63:0]      app_rxd;
  logic [7:0]       app_rxc;
  logic [NP-1:0]    tx_en_cur;
  logic [SW-1:0]    rx_sel_cur;
  logic [31:0]      rx_frame_cnt;
  logic [15:0]      rx_abort_cnt;

  xgmii_port_switch #(.NPORTS(NP), .SELW(SW)) dut (
    .xgmii_clk    (clk),
    .sys_rst      (sys_rst),
    .app_txd      (app_txd),
    .app_txc      (app_txc),
    .tx_en_req    (tx_en_req),
    .port_txd     (port_txd),
    .port_txc     (port_txc),
    .port_rxd     (port_rxd),
    .port_rxc     (port_rxc),
    .link_up      (link_up),
    .rx_sel_req   (rx_sel_req),
    .app_rxd      (app_rxd),
    .app_rxc      (app_rxc),
    .tx_en_cur    (tx_en_cur),
    .rx_sel_cur   (rx_sel_cur),
    .rx_frame_cnt (rx_frame_cnt),
    .rx_abort_cnt (rx_abort_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Reference model state.
  bit              m_txf, m_rxf, m_hunt;
  logic [NP-1:0]   m_en;
  int              m_sel;
  logic [31:0]     m_fcnt;
  logic [15:0]     m_acnt;
  logic [NP*64-1:0] e_ptxd;
  logic [NP*8-1:0]  e_ptxc;
  logic [63:0]     e_rxd;
  logic [7:0]      e_rxc;

  // Lane of the Start code (0 or 4), or -1 when absent.
  function automatic int start_lane(input logic [63:0] d, input logic [7:0] c);
    if (c[0] && d[7:0] == 8'hFB) return 0;
    if (c[4] && d[39:32] == 8'hFB) return 4;
    return -1;
  endfunction

  function automatic int first_term(input logic [63:0] d, input logic [7:0] c);
    for (int k = 0; k < 8; k++) if (c[k] && d[8*k +: 8] == 8'hFD) return k;
    return -1;
  endfunction

  function automatic bit frame_after(input bit cur, input logic [63:0] d, input logic [7:0] c);
    int s, t;
    s = start_lane(d, c);
    t = first_term(d, c);
    if (s >= 0 && (t < 0 || t < s)) return 1'b1;
    if (t >= 0) return 1'b0;
    return cur;
  endfunction

  task automatic model_step();
    logic [63:0] w;
    logic [7:0]  wc;
    bit          up;
    int          s;
    if (sys_rst) begin
      m_txf = 0; m_rxf = 0; m_hunt = 1; m_en = '0; m_sel = 0; m_fcnt = 0; m_acnt = 0;
      e_ptxd = {NP{IdleD}}; e_ptxc = '1; e_rxd = IdleD; e_rxc = 8'hFF;
      return;
    end
    for (int p = 0; p < NP; p++) begin
      e_ptxd[64*p +: 64] = m_en[p] ? app_txd : IdleD;
      e_ptxc[8*p +: 8]   = m_en[p] ? app_txc : 8'hFF;
    end
    if (!m_txf && start_lane(app_txd, app_txc) < 0) m_en = tx_en_req;
    m_txf = frame_after(m_txf, app_txd, app_txc);

    w  = port_rxd[64*m_sel +: 64];
    wc = port_rxc[8*m_sel +: 8];
    up = link_up[m_sel];
    s  = start_lane(w, wc);
    e_rxd = IdleD;
    e_rxc = 8'hFF;
    if (m_hunt) begin
      if (int'(rx_sel_req) != m_sel) m_sel = int'(rx_sel_req);
      else if (up && s >= 0) begin
        e_rxd  = (s == 0) ? w : {w[63:32], IdleD[31:0]};
        e_rxc  = (s == 0) ? wc : {wc[7:4], 4'hF};
        m_hunt = 0;
        if (first_term(e_rxd, e_rxc) >= 0) m_fcnt++;
      end
    end else if (!up) begin
      m_hunt = 1;
      if (m_rxf) begin
        e_rxd = AbortD;
        if (m_acnt != 16'hFFFF) m_acnt++;
      end
    end else if (int'(rx_sel_req) != m_sel && !m_rxf && s < 0) begin
      m_sel  = int'(rx_sel_req);
      m_hunt = 1;
    end else begin
      e_rxd = w;
      e_rxc = wc;
      if (first_term(w, wc) >= 0) m_fcnt++;
    end
    m_rxf = frame_after(m_rxf, w, wc);
  endtask

  task automatic compare_all();
    check("port_txd", port_txd, e_ptxd);
    check("port_txc", port_txc, e_ptxc);
    check("app_rxd", app_rxd, e_rxd);
    check("app_rxc", app_rxc, e_rxc);
    check("tx_en_cur", tx_en_cur, m_en);
    check("rx_sel_cur", rx_sel_cur, m_sel);
    check("rx_frame_cnt", rx_frame_cnt, m_fcnt);
    check("rx_abort_cnt", rx_abort_cnt, m_acnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  // Frame generators: stream index NP is TX, 0..NP-1 are RX ports.
  int rem [NP+1];
  int ldown [NP];

  task automatic gen(input int s, output logic [63:0] d, output logic [7:0] c);
    logic [63:0] r;
    int t;
    r = {$urandom, $urandom};
    d = IdleD;
    c = 8'hFF;
    if (rem[s] == 0) begin
      if ($urandom_range(2) == 0) begin
        if ($urandom_range(1) == 1) begin
          d = {r[63:8], 8'hFB}; c = 8'h01;
        end else begin
          d = {r[63:40], 8'hFB, IdleD[31:0]}; c = 8'h1F;
        end
        rem[s] = $urandom_range(4, 1);
      end
    end else if (rem[s] > 1) begin
      d = r; c = 8'h00; rem[s]--;
    end else begin
      t = $urandom_range(7);
      for (int k = 0; k < 8; k++) begin
        if (k < t) begin d[8*k +: 8] = r[8*k +: 8]; c[k] = 1'b0; end
        else if (k == t) begin d[8*k +: 8] = 8'hFD; c[k] = 1'b1; end
      end
      if (t < 4 && $urandom_range(3) == 0) begin
        d[39:32] = 8'hFB; c[4] = 1'b1;
        d[63:40] = r[63:40]; c[7:5] = 3'b000;
        rem[s] = $urandom_range(4, 1);
      end else begin
        rem[s] = 0;
      end
    end
  endtask

  task automatic set_idle();
    app_txd  = IdleD;
    app_txc  = 8'hFF;
    port_rxd = {NP{IdleD}};
    port_rxc = '1;
    for (int s = 0; s <= NP; s++) rem[s] = 0;
  endtask

  task automatic set_rx(input int p, input logic [63:0] d, input logic [7:0] c);
    port_rxd[64*p +: 64] = d;
    port_rxc[8*p +: 8]   = c;
  endtask

  initial begin
    logic [63:0] d;
    logic [7:0]  c;
    sys_rst    = 1'b1;
    tx_en_req  = 4'b0001;
    rx_sel_req = '0;
    link_up    = '1;
    set_idle();
    for (int p = 0; p < NP; p++) ldown[p] = 0;
    tick();
    tick();
    sys_rst = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      sys_rst = (cyc == 1700 || cyc == 1701);
      gen(NP, d, c);
      app_txd = d;
      app_txc = c;
      for (int p = 0; p < NP; p++) begin
        gen(p, d, c);
        set_rx(p, d, c);
        if (ldown[p] > 0) ldown[p]--;
        else if ($urandom_range(79) == 0) ldown[p] = $urandom_range(6, 1);
        link_up[p] = (ldown[p] == 0);
      end
      if ($urandom_range(39) == 0) tx_en_req = 4'($urandom_range(15));
      if ($urandom_range(39) == 0) rx_sel_req = 2'($urandom_range(3));
      tick();
    end

    // Quiet the link, then preload the counters to their limits.
    sys_rst    = 1'b0;
    rx_sel_req = 2'(m_sel);
    link_up    = '1;
    set_idle();
    repeat (4) tick();
    force dut.rx_abort_cnt_q = 16'hFFFF;
    force dut.rx_frame_cnt_q = 32'hFFFF_FFFF;
    m_acnt = 16'hFFFF;
    m_fcnt = 32'hFFFF_FFFF;
    tick();
    release dut.rx_abort_cnt_q;
    release dut.rx_frame_cnt_q;
    tick();

    set_rx(m_sel, 64'h665544332211AAFB, 8'h01);
    tick();
    set_rx(m_sel, 64'h0123456789ABCDEF, 8'h00);
    tick();
    set_rx(m_sel, 64'h07070707FD332211, 8'hF8);
    tick();
    check("frame_wrap", rx_frame_cnt, 32'h0);
    set_rx(m_sel, IdleD, 8'hFF);
    tick();

    set_rx(m_sel, 64'h665544332211AAFB, 8'h01);
    tick();
    set_rx(m_sel, 64'h1122334455667788, 8'h00);
    tick();
    set_rx(m_sel, 64'h99AABBCCDDEEFF00, 8'h00);
    link_up[m_sel] = 1'b0;
    tick();
    check("abort_sat", rx_abort_cnt, 16'hFFFF);
    check("abort_word", {app_rxc, app_rxd}, {8'hFF, AbortD});
    set_rx(m_sel, IdleD, 8'hFF);
    tick();
    check("idle_after_abort", app_rxd, IdleD);
    link_up = '1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
